// File: rtl/rca_word_sequencer.sv
// Word-serial wide adder front end driving one external N-bit ripple-carry adder.
// Optional signed-overflow output enabled by defining RCA_SEQ_OVF_EN.
module rca_word_sequencer #(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4,
    parameter int unsigned CNTW  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_A,
    input  logic [N-1:0] in_B,
    input  logic         in_cin,
    output logic [N-1:0] rca_A,
    output logic [N-1:0] rca_B,
    output logic         rca_cin,
    input  logic [N-1:0] rca_Sum,
    input  logic         rca_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_Sum,
    output logic         out_last,
    output logic         out_cout
`ifdef RCA_SEQ_OVF_EN
    ,
    output logic         out_ovf
`endif
);

    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_RUN    = 1'b1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WORDS - 1);

    logic [0:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            out_valid_d;
    logic [N-1:0]    out_sum_d;
    logic            out_last_d;
    logic            out_cout_d;
    logic            accept;
    logic            take;
    logic            is_last;
`ifdef RCA_SEQ_OVF_EN
    logic            out_ovf_d;
`endif

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign is_last  = (cnt_q == LAST_CNT);

    // The carry seed only enters on word 0; later words chain the registered carry.
    assign rca_A   = in_A;
    assign rca_B   = in_B;
    assign rca_cin = (cnt_q == '0) ? in_cin : carry_q;

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid;
        out_sum_d   = out_Sum;
        out_last_d  = out_last;
        out_cout_d  = out_cout;
`ifdef RCA_SEQ_OVF_EN
        out_ovf_d   = out_ovf;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = rca_Sum;
            carry_d     = rca_cout;
            out_last_d  = is_last;
            out_cout_d  = rca_cout & is_last;
`ifdef RCA_SEQ_OVF_EN
            out_ovf_d   = is_last & (in_A[N-1] == in_B[N-1]) & (rca_Sum[N-1] != in_A[N-1]);
`endif
            cnt_d       = is_last ? '0 : cnt_q + CNTW'(1);
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = is_last ? S_IDLE : S_RUN;
                default: state_d = S_IDLE;
            endcase
        end else if (take) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            out_Sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            out_valid <= out_valid_d;
            out_Sum   <= out_sum_d;
            out_last  <= out_last_d;
            out_cout  <= out_cout_d;
`ifdef RCA_SEQ_OVF_EN
            out_ovf   <= out_ovf_d;
`endif
        end
    end

endmodule
